// File: rtl/alu_byte_sequencer_pkg.sv
// Shared types and constants for the byte-serial ALU sequencer and its bench.
package alu_byte_sequencer_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Eight-bit ALU select codes. Logic ops pass the carry through unchanged
    // so a multi-byte chain still reports the incoming carry as COUT.
    localparam logic [2:0] ALU_OP_ADD   = 3'd0; // A + B + CIN
    localparam logic [2:0] ALU_OP_SUB   = 3'd1; // A + ~B + CIN (CIN=1 gives A-B)
    localparam logic [2:0] ALU_OP_AND   = 3'd2;
    localparam logic [2:0] ALU_OP_OR    = 3'd3;
    localparam logic [2:0] ALU_OP_XOR   = 3'd4;
    localparam logic [2:0] ALU_OP_NOTA  = 3'd5;
    localparam logic [2:0] ALU_OP_SHL   = 3'd6; // {A[6:0], CIN}, COUT = A[7]
    localparam logic [2:0] ALU_OP_PASSB = 3'd7;

endpackage

// File: rtl/alu_byte_sequencer_alu.sv
// Existing eight-bit ALU slice; purely combinational, one byte per evaluation.
module eightBitALU
    import alu_byte_sequencer_pkg::*;
(
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       CIN,
    input  logic [2:0] OP,
    output logic [7:0] ALU_OUT,
    output logic       ALU_COUT
);

    logic [8:0] sum;

    // Select the byte result and carry-out for the current op code.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        sum      = 9'd0;
        ALU_OUT  = 8'd0;
        ALU_COUT = CIN;
        case (OP)
            ALU_OP_ADD: begin
                sum      = {1'b0, A} + {1'b0, B} + {8'd0, CIN};
                ALU_OUT  = sum[7:0];
                ALU_COUT = sum[8];
            end
            ALU_OP_SUB: begin
                sum      = {1'b0, A} + {1'b0, ~B} + {8'd0, CIN};
                ALU_OUT  = sum[7:0];
                ALU_COUT = sum[8];
            end
            ALU_OP_AND:   ALU_OUT = A & B;
            ALU_OP_OR:    ALU_OUT = A | B;
            ALU_OP_XOR:   ALU_OUT = A ^ B;
            ALU_OP_NOTA:  ALU_OUT = ~A;
            ALU_OP_SHL: begin
                ALU_OUT  = {A[6:0], CIN};
                ALU_COUT = A[7];
            end
            default:      ALU_OUT = B;
        endcase
    end

endmodule

// File: rtl/alu_byte_sequencer.sv
// Multi-byte ALU operation executed LSB-first through one shared eight-bit ALU,
// rippling the carry from byte to byte across consecutive clock cycles.
module alu_byte_sequencer
    import alu_byte_sequencer_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [8*NBYTES-1:0] req_a,
    input  logic [8*NBYTES-1:0] req_b,
    input  logic                req_cin,
    input  logic [2:0]          req_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [8*NBYTES-1:0] rsp_result,
    output logic                rsp_cout,
    output logic                busy
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [W-1:0]     result_q, result_d;

    logic [7:0]       alu_a, alu_b, alu_out;
    logic             alu_cout;

    // Current byte of the captured operands; only registered values feed the ALU.
    assign alu_a = a_q[{idx_q, 3'b000} +: 8];
    assign alu_b = b_q[{idx_q, 3'b000} +: 8];

    eightBitALU u_alu (
        .A        (alu_a),
        .B        (alu_b),
        .CIN      (carry_q),
        .OP       (op_q),
        .ALU_OUT  (alu_out),
        .ALU_COUT (alu_cout)
    );

    // Next-state logic: capture in IDLE, one byte per RUN cycle, hold in DONE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    carry_d = req_cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[{idx_q, 3'b000} +: 8] = alu_out;
                carry_d = alu_cout;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand and result registers are reset as well so rsp_result reads a defined 0 after reset.
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= ALU_OP_ADD;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_result = result_q;
    assign rsp_cout   = carry_q;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Scoreboard bench: three sequencers (4, 2 and 8 bytes) share operand inputs,
// each has its own req_valid; expected results come from a full-width model.
module tb_alu_byte_sequencer;
    import alu_byte_sequencer_pkg::*;

    typedef struct packed {
        logic [63:0] res;
        logic        co;
    } exp_t;

    logic        clk, rst_n, rsp_ready, req_cin;
    logic [63:0] req_a, req_b;
    logic [2:0]  req_op;
    logic        v4, v2, v8;
    logic        rdy4, rdy2, rdy8, val4, val2, val8, co4, co2, co8, busy4, busy2, busy8;
    logic [31:0] res4;
    logic [15:0] res2;
    logic [63:0] res8;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t q4[$], q2[$], q8[$];

    alu_byte_sequencer #(.NBYTES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(rdy4),
        .req_a(req_a[31:0]), .req_b(req_b[31:0]), .req_cin(req_cin), .req_op(req_op),
        .rsp_valid(val4), .rsp_ready(rsp_ready), .rsp_result(res4), .rsp_cout(co4), .busy(busy4));

    alu_byte_sequencer #(.NBYTES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2),
        .req_a(req_a[15:0]), .req_b(req_b[15:0]), .req_cin(req_cin), .req_op(req_op),
        .rsp_valid(val2), .rsp_ready(rsp_ready), .rsp_result(res2), .rsp_cout(co2), .busy(busy2));

    alu_byte_sequencer #(.NBYTES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req_valid(v8), .req_ready(rdy8),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_op(req_op),
        .rsp_valid(val8), .rsp_ready(rsp_ready), .rsp_result(res8), .rsp_cout(co8), .busy(busy8));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Whole-word reference: arithmetic done at full width, not byte by byte.
    function automatic exp_t model(input int nb, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic [2:0] op);
        int          w;
        logic [63:0] mask;
        logic [64:0] full;
        exp_t        e;
        w    = 8 * nb;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a    = a & mask;
        b    = b & mask;
        e.co = cin;
        full = '0;
        case (op)
            ALU_OP_ADD: begin full = {1'b0, a} + {1'b0, b} + 65'(cin); e.res = full[63:0] & mask; e.co = full[w]; end
            ALU_OP_SUB: begin full = {1'b0, a} + {1'b0, ~b & mask} + 65'(cin); e.res = full[63:0] & mask; e.co = full[w]; end
            ALU_OP_AND:  e.res = a & b;
            ALU_OP_OR:   e.res = a | b;
            ALU_OP_XOR:  e.res = a ^ b;
            ALU_OP_NOTA: e.res = ~a & mask;
            ALU_OP_SHL:  begin e.res = ((a << 1) | 64'(cin)) & mask; e.co = a[w-1]; end
            default:     e.res = b;
        endcase
        return e;
    endfunction

    // Scoreboard: push on each accept, pop and compare on each response handshake.
    always @(negedge clk) begin
        exp_t e;
        int   n;
        if (rst_n) begin
            if (v4 && rdy4) q4.push_back(model(4, req_a, req_b, req_cin, req_op));
            if (v2 && rdy2) q2.push_back(model(2, req_a, req_b, req_cin, req_op));
            if (v8 && rdy8) q8.push_back(model(8, req_a, req_b, req_cin, req_op));
            if (val4 && rsp_ready) begin
                n = q4.size();
                if (n == 0) check("rsp4_spurious", 64'(n), 64'd1);
                else begin e = q4.pop_front(); check("res4", 64'(res4), e.res); check("cout4", 64'(co4), 64'(e.co)); end
            end
            if (val2 && rsp_ready) begin
                n = q2.size();
                if (n == 0) check("rsp2_spurious", 64'(n), 64'd1);
                else begin e = q2.pop_front(); check("res2", 64'(res2), e.res); check("cout2", 64'(co2), 64'(e.co)); end
            end
            if (val8 && rsp_ready) begin
                n = q8.size();
                if (n == 0) check("rsp8_spurious", 64'(n), 64'd1);
                else begin e = q8.pop_front(); check("res8", res8, e.res); check("cout8", 64'(co8), 64'(e.co)); end
            end
        end
    end

    function automatic logic rdy_of(input int which);
        case (which)
            2:       return rdy2;
            8:       return rdy8;
            default: return rdy4;
        endcase
    endfunction

    task automatic set_valid(input int which, input logic v);
        case (which)
            2:       v2 = v;
            8:       v8 = v;
            default: v4 = v;
        endcase
    endtask

    // Present one request and return 1 time unit after the accepting edge.
    task automatic send(input int which, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic [2:0] op);
        logic acc;
        acc    = 1'b0;
        req_a  = a;
        req_b  = b;
        req_cin = cin;
        req_op = op;
        set_valid(which, 1'b1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy_of(which)) begin acc = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        set_valid(which, 1'b0);
        check("accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (q4.size() == 0 && q2.size() == 0 && q8.size() == 0 && !busy4 && !busy2 && !busy8) break;
        end
        check("drain", 64'(q4.size() + q2.size() + q8.size()), 64'd0);
    endtask

    initial begin
        int   n, acc1, acc2;
        exp_t e;

        rst_n = 1'b0; rsp_ready = 1'b1; req_cin = 1'b0; req_op = ALU_OP_ADD;
        req_a = '0; req_b = '0; v4 = 1'b0; v2 = 1'b0; v8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy4), 64'd0);
        check("rst_valid", 64'(val4), 64'd0);
        check("rst_result", 64'(res4), 64'd0);
        check("rst_cout", 64'(co4), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 64'(rdy4), 64'd1);

        // Carry ripples through every byte; response 4 edges after accept.
        send(4, 64'hFFFF_FFFF, 64'h0000_0001, 1'b0, ALU_OP_ADD);
        check("run_busy", 64'(busy4), 64'd1);
        check("run_ready", 64'(rdy4), 64'd0);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (val4) begin n = i; break; end
        end
        check("latency", 64'(n), 64'd4);
        check("ripple_res", 64'(res4), 64'h0);
        check("ripple_cout", 64'(co4), 64'd1);
        drain();

        // Carry-in enters at byte 0.
        send(4, 64'h0000_00FF, 64'h0, 1'b1, ALU_OP_ADD);
        drain();

        // Backpressure: result held while a second request waits.
        rsp_ready = 1'b0;
        send(4, 64'h1234_5678, 64'h0F0F_0F0F, 1'b1, ALU_OP_SUB);
        e = model(4, 64'h1234_5678, 64'h0F0F_0F0F, 1'b1, ALU_OP_SUB);
        for (int i = 0; i < 20 && !val4; i++) begin @(posedge clk); #1; end
        req_a = 64'hA5A5_5A5A; req_b = 64'h3C3C_C3C3; req_op = ALU_OP_XOR; req_cin = 1'b0;
        v4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(val4), 64'd1);
            check("bp_hold", 64'(res4), e.res);
            check("bp_ready", 64'(rdy4), 64'd0);
        end
        rsp_ready = 1'b1;
        send(4, 64'hA5A5_5A5A, 64'h3C3C_C3C3, 1'b0, ALU_OP_XOR);
        drain();

        // Reset at byte index 2 discards the operation.
        send(4, 64'h8765_4321, 64'h1111_1111, 1'b0, ALU_OP_ADD);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy4), 64'd0);
        check("mid_rst_valid", 64'(val4), 64'd0);
        q4.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(4, 64'h0001_FFFF, 64'h0000_0001, 1'b0, ALU_OP_SHL);
        drain();

        // Back-to-back with req_valid held: second accept NBYTES+2 edges later.
        req_a = 64'hDEAD_BEEF; req_b = 64'h0123_4567; req_cin = 1'b1; req_op = ALU_OP_ADD;
        v4 = 1'b1;
        acc1 = -1; acc2 = -1;
        for (int i = 0; i < 50; i++) begin @(negedge clk); if (rdy4) break; end
        @(posedge clk); #1; acc1 = cyc;
        req_a = 64'h0F0F_F0F0; req_b = 64'hFFFF_0000; req_cin = 1'b0; req_op = ALU_OP_OR;
        for (int i = 0; i < 50; i++) begin @(negedge clk); if (rdy4) break; end
        @(posedge clk); #1; acc2 = cyc;
        v4 = 1'b0;
        check("b2b_spacing", 64'(acc2 - acc1), 64'd6);
        drain();

        // Random ops and operands on the 2-byte and 8-byte instances.
        for (int i = 0; i < 25; i++)
            send(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 3'($urandom));
        drain();
        for (int i = 0; i < 25; i++)
            send(8, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 3'($urandom));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_byte_sequencer.md
ALU_BYTE_SEQUENCER -- requirements
Module: alu_byte_sequencer

Interface
REQ-001 Parameter: NBYTES, 4, operand width in bytes (legal range 2..8); operand width W = 8*NBYTES.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  1  request present.
REQ-005 Port: req_ready  output  1  sequencer can accept a request.
REQ-006 Port: req_a  input  W  operand A.
REQ-007 Port: req_b  input  W  operand B.
REQ-008 Port: req_cin  input  1  carry-in applied to byte 0.
REQ-009 Port: req_op  input  3  ALU select code, passed unchanged to the ALU for every byte.
REQ-010 Port: rsp_valid  output  1  result available.
REQ-011 Port: rsp_ready  input  1  consumer accepts result.
REQ-012 Port: rsp_result  output  W  multi-byte result.
REQ-013 Port: rsp_cout  output  1  carry-out of the most significant byte.
REQ-014 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states IDLE, RUN, DONE; encoding type in the shared package.
REQ-016 IDLE: req_ready=1, rsp_valid=0; on req_valid&&req_ready, capture req_a, req_b, req_op, req_cin, clear byte index to 0, go RUN.
REQ-017 req_ready SHALL be 0 in RUN and DONE; requests are not accepted in those states.
REQ-018 RUN, each cycle: drive the eight-bit ALU with a[idx], b[idx], carry register, captured op; at the clock edge write ALU_OUT into result byte idx and ALU_COUT into the carry register.
REQ-019 Byte 0 uses captured req_cin; byte k>0 uses the ALU_COUT registered from byte k-1 (ripple across cycles, LSB first).
REQ-020 Index increments by 1 per RUN cycle; when idx==NBYTES-1 the write completes and state goes DONE; idx never exceeds NBYTES-1.
REQ-021 Latency: rsp_valid rises exactly NBYTES clock edges after the accepting edge.
REQ-022 DONE: rsp_valid=1; rsp_result and rsp_cout stable until handshake; on rsp_ready go IDLE at that edge.
REQ-023 rsp_ready while not DONE is ignored; rsp_ready held high means DONE lasts one cycle.
REQ-024 Captured operands SHALL NOT change while busy, regardless of req_* activity.
REQ-025 Minimum request-to-request spacing NBYTES+2 cycles (accept, NBYTES RUN cycles, DONE).
REQ-026 Carry chaining is applied for every op code; rsp_cout is the ALU's final COUT whatever the op.

Reset
REQ-027 rst_n low forces immediately: state IDLE, idx 0, carry register 0, result register 0, rsp_valid 0, rsp_cout 0, busy 0; req_ready 1 once rst_n is high.
REQ-028 Reset during RUN or DONE discards the operation; no rsp_valid is produced for it.
REQ-029 Deassertion of rst_n is synchronized by the integrating level; first acceptance possible on the first edge with rst_n high.

Structure
REQ-030 Shared package holds the FSM state type and the ALU op-code constants (ALU_OP_ADD and siblings) used by bench and RTL.
REQ-031 Exactly one sub-module instance: the existing eightBitALU, single instance time-shared across bytes; no second ALU.
REQ-032 Byte selection is an indexed part-select on the captured operands; no combinational path from req_* to rsp_*.

Verification
REQ-033 Add with carry ripple: op=ALU_OP_ADD, A=0xFFFF_FFFF, B=0x0000_0001, cin=0 -> result 0x0000_0000, cout=1, rsp_valid 4 edges after accept.
REQ-034 Carry-in: op=ALU_OP_ADD, A=0x0000_00FF, B=0x0000_0000, cin=1 -> result 0x0000_0100, cout=0.
REQ-035 Backpressure: rsp_ready low 5 cycles in DONE -> result held constant, req_ready stays 0, second req_valid ignored until IDLE.
REQ-036 Reset mid-RUN: rst_n low at idx=2 -> busy 0 and rsp_valid 0 same cycle; next request completes correctly.
REQ-037 Back-to-back: req_valid held high with two operand sets -> second accepted exactly NBYTES+2 cycles after the first; both results match the byte-wise eightBitALU model.
REQ-038 Random ops/operands, NBYTES=2 and 8 -> results match golden model of chained eightBitALU per byte.
